// File: rtl/pes_elevator_scheduler.sv
// SCAN up/down sweep scheduler feeding one-hot targets to the elevator motion core.
// Optional express-to-floor-0 dispatch is enabled by defining PES_SCHED_EXPRESS_EN.
module pes_elevator_scheduler #(
    parameter int unsigned FLOORS       = 8,
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [FLOORS-1:0] call_req_i,
    input  logic [FLOORS-1:0] cur_floor_i,
    input  logic              move_complete_i,
    input  logic              over_weight_i,
`ifdef PES_SCHED_EXPRESS_EN
    input  logic              express_req_i,
`endif
    output logic [FLOORS-1:0] target_floor_o,
    output logic              target_valid_o,
    output logic              direction_o,
    output logic              door_open_o,
    output logic [FLOORS-1:0] pending_o,
    output logic              busy_o,
    output logic              err_alert_o
);

    typedef enum logic [2:0] {StIdle, StSelect, StDispatch, StDoor, StHold} state_e;

    state_e             state_q, state_d;
    logic [FLOORS-1:0]  pending_q, pending_d;
    logic [FLOORS-1:0]  tgt_q, tgt_d;
    logic               tv_q, tv_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               cur_onehot;
    logic [FLOORS-1:0]  below_mask, above, below, lo_above, hi_below;
    logic [FLOORS-1:0]  call_mask, clr;
    logic               express;

    assign cur_onehot = (cur_floor_i != '0) && ((cur_floor_i & (cur_floor_i - FLOORS'(1))) == '0);
    assign below_mask = cur_floor_i - FLOORS'(1);
    assign above      = pending_q & ~(below_mask | cur_floor_i);
    assign below      = pending_q & below_mask;

`ifdef PES_SCHED_EXPRESS_EN
    assign express = express_req_i;
`else
    assign express = 1'b0;
`endif

    // Nearest pending floor on each side of the car.
    always_comb begin
        lo_above = '0;
        hi_below = '0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (above[i]) begin
                lo_above    = '0;
                lo_above[i] = 1'b1;
            end
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (below[i]) begin
                hi_below    = '0;
                hi_below[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        tv_d      = tv_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        err_d     = err_q | ~cur_onehot;
        clr       = '0;
        call_mask = call_req_i;

        // Calls for the floor being served only re-open the door.
        if (state_q == StDoor || state_q == StHold) begin
            call_mask = call_req_i & ~cur_floor_i;
        end

        unique case (state_q)
            StIdle: begin
                if (!err_d) begin
                    if ((pending_q & cur_floor_i) != '0) begin
                        state_d = StDoor;
                        cnt_d   = '0;
                    end else if (pending_q != '0) begin
                        state_d = StSelect;
                    end
                end
            end
            StSelect: begin
                state_d = StDispatch;
                tv_d    = 1'b1;
                if (express) begin
                    tgt_d    = '0;
                    tgt_d[0] = 1'b1;
                    dir_d    = 1'b0;
                end else if (dir_q && above != '0) begin
                    tgt_d = lo_above;
                end else if (!dir_q && below != '0) begin
                    tgt_d = hi_below;
                end else if (dir_q && below != '0) begin
                    tgt_d = hi_below;
                    dir_d = 1'b0;
                end else if (!dir_q && above != '0) begin
                    tgt_d = lo_above;
                    dir_d = 1'b1;
                end else begin
                    // Only the current floor was pending; IDLE opens the door.
                    state_d = StIdle;
                    tv_d    = 1'b0;
                end
            end
            StDispatch: begin
                if (move_complete_i) begin
                    state_d = StDoor;
                    tgt_d   = '0;
                    tv_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            StDoor: begin
                if ((call_req_i & cur_floor_i) != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                    state_d = over_weight_i ? StHold : StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHold: begin
                if (!over_weight_i) begin
                    state_d = StDoor;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StDoor && state_q != StDoor) begin
            clr = cur_floor_i;
        end
        pending_d = (pending_q | call_mask) & ~clr;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pending_q <= '0;
            tgt_q     <= '0;
            tv_q      <= 1'b0;
            dir_q     <= 1'b1;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            tgt_q     <= tgt_d;
            tv_q      <= tv_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign target_floor_o = tgt_q;
    assign target_valid_o = tv_q;
    assign direction_o    = dir_q;
    assign door_open_o    = (state_q == StDoor) || (state_q == StHold);
    assign pending_o      = pending_q;
    assign busy_o         = (state_q != StIdle);
    assign err_alert_o    = err_q;

endmodule
